// File: rtl/tage_hist_hash.sv
// rtl/tage_hist_hash.sv - TAGE table index/tag hash with GHR and folded histories
// Optional macro TAGE_HIST_CKPT_EN: checkpoint history on lookup, restore it on flush.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

module tage_hist_hash #(
   parameter int PC_W     = 32,
   parameter int IDX_W    = `TAGE_IDX_WIDTH,
   parameter int TAG_W    = 9,
   parameter int HIST_LEN = 32,
   parameter int GHR_LEN  = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pc_valid_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic               br_valid_i,
   input  logic               br_taken_i,
   input  logic               flush_i,
   output logic [IDX_W-1:0]   hash_idx_o,
   output logic [TAG_W-1:0]   hash_tag_o,
   output logic               hash_valid_o,
   output logic [GHR_LEN-1:0] ghr_o
);

   localparam int T2_W   = TAG_W - 1;
   localparam int SH_IDX = HIST_LEN % IDX_W;
   localparam int SH_T1  = HIST_LEN % TAG_W;
   localparam int SH_T2  = HIST_LEN % T2_W;

   logic [GHR_LEN-1:0] ghr_q, ghr_base, ghr_d;
   logic [IDX_W-1:0]   fidx_q, fidx_base, fidx_d;
   logic [TAG_W-1:0]   ft1_q, ft1_base, ft1_d;
   logic [T2_W-1:0]    ft2_q, ft2_base, ft2_d;
   logic               old_bit;
   logic [IDX_W-1:0]   idx_calc;
   logic [TAG_W-1:0]   tag_calc;
   logic               lookup;

   logic unused_pc;
   assign unused_pc = ^{pc_i[1:0], pc_i[PC_W-1:2*IDX_W+2]};

   assign lookup = pc_valid_i && !flush_i;

`ifdef TAGE_HIST_CKPT_EN
   logic [GHR_LEN-1:0] ck_ghr_q;
   logic [IDX_W-1:0]   ck_fidx_q;
   logic [TAG_W-1:0]   ck_ft1_q;
   logic [T2_W-1:0]    ck_ft2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ck_ghr_q  <= '0;
         ck_fidx_q <= '0;
         ck_ft1_q  <= '0;
         ck_ft2_q  <= '0;
      end else if (lookup) begin
         ck_ghr_q  <= ghr_q;
         ck_fidx_q <= fidx_q;
         ck_ft1_q  <= ft1_q;
         ck_ft2_q  <= ft2_q;
      end
   end
`endif

   // Flush picks the repaired base first; a same-cycle outcome is then shifted onto it.
   always_comb begin
      ghr_base  = ghr_q;
      fidx_base = fidx_q;
      ft1_base  = ft1_q;
      ft2_base  = ft2_q;
      if (flush_i) begin
`ifdef TAGE_HIST_CKPT_EN
         ghr_base  = ck_ghr_q;
         fidx_base = ck_fidx_q;
         ft1_base  = ck_ft1_q;
         ft2_base  = ck_ft2_q;
`else
         ghr_base  = '0;
         fidx_base = '0;
         ft1_base  = '0;
         ft2_base  = '0;
`endif
      end
      old_bit = ghr_base[HIST_LEN-1];
      ghr_d   = ghr_base;
      fidx_d  = fidx_base;
      ft1_d   = ft1_base;
      ft2_d   = ft2_base;
      if (br_valid_i) begin
         ghr_d  = {ghr_base[GHR_LEN-2:0], br_taken_i};
         fidx_d = {fidx_base[IDX_W-2:0], fidx_base[IDX_W-1]}
                ^ {{(IDX_W-1){1'b0}}, br_taken_i}
                ^ ({{(IDX_W-1){1'b0}}, old_bit} << SH_IDX);
         ft1_d  = {ft1_base[TAG_W-2:0], ft1_base[TAG_W-1]}
                ^ {{(TAG_W-1){1'b0}}, br_taken_i}
                ^ ({{(TAG_W-1){1'b0}}, old_bit} << SH_T1);
         ft2_d  = {ft2_base[T2_W-2:0], ft2_base[T2_W-1]}
                ^ {{(T2_W-1){1'b0}}, br_taken_i}
                ^ ({{(T2_W-1){1'b0}}, old_bit} << SH_T2);
      end
   end

   assign idx_calc = pc_i[IDX_W+1:2] ^ pc_i[2*IDX_W+1:IDX_W+2] ^ fidx_q;
   assign tag_calc = pc_i[TAG_W+1:2] ^ ft1_q ^ {ft2_q, 1'b0};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ghr_q        <= '0;
         fidx_q       <= '0;
         ft1_q        <= '0;
         ft2_q        <= '0;
         hash_idx_o   <= '0;
         hash_tag_o   <= '0;
         hash_valid_o <= 1'b0;
      end else begin
         ghr_q        <= ghr_d;
         fidx_q       <= fidx_d;
         ft1_q        <= ft1_d;
         ft2_q        <= ft2_d;
         hash_valid_o <= lookup;
         if (lookup) begin
            hash_idx_o <= idx_calc;
            hash_tag_o <= tag_calc;
         end
      end
   end

   assign ghr_o = ghr_q;

endmodule

// File: tb/tb_tage_hist_hash.sv
// tb/tb_tage_hist_hash.sv - self-checking bench for tage_hist_hash
// Expected hashes come from chunk-folding a model GHR; honours TAGE_HIST_CKPT_EN.
`timescale 1ns/1ps
module tb_tage_hist_hash;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_valid = 1'b0;
   logic [31:0] pc = '0;
   logic        br_valid = 1'b0;
   logic        br_taken = 1'b0;
   logic        flush = 1'b0;
   logic [9:0]  hash_idx;
   logic [8:0]  hash_tag;
   logic        hash_valid;
   logic [63:0] ghr;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [63:0] m_ghr, m_ckpt;
   logic        e_valid;
   logic [9:0]  e_idx;
   logic [8:0]  e_tag;

   tage_hist_hash #(.PC_W(32), .IDX_W(10), .TAG_W(9), .HIST_LEN(32), .GHR_LEN(64)) dut (
      .clk_i(clk), .rst_i(rst), .pc_valid_i(pc_valid), .pc_i(pc),
      .br_valid_i(br_valid), .br_taken_i(br_taken), .flush_i(flush),
      .hash_idx_o(hash_idx), .hash_tag_o(hash_tag), .hash_valid_o(hash_valid), .ghr_o(ghr)
   );

   always #5 clk = ~clk;

   // Every history bit i of the last 32 outcomes lands at position i mod w.
   function automatic logic [15:0] fold(input logic [63:0] h, input int w);
      logic [15:0] r = '0;
      for (int i = 0; i < 32; i++) if (h[i]) r[i % w] = ~r[i % w];
      return r;
   endfunction

   function automatic logic [9:0] model_idx(input logic [31:0] p, input logic [63:0] h);
      logic [15:0] f = fold(h, 10);
      return p[11:2] ^ p[21:12] ^ f[9:0];
   endfunction

   function automatic logic [8:0] model_tag(input logic [31:0] p, input logic [63:0] h);
      logic [15:0] f1 = fold(h, 9);
      logic [15:0] f2 = fold(h, 8);
      logic [8:0]  sh = {f2[7:0], 1'b0};
      return p[10:2] ^ f1[8:0] ^ sh;
   endfunction

   task automatic cycle(input logic pv, input logic [31:0] p, input logic bv,
                        input logic bt, input logic fl);
      logic [63:0] base;
      pc_valid = pv; pc = p; br_valid = bv; br_taken = bt; flush = fl;
      base = m_ghr;
      if (fl) begin
`ifdef TAGE_HIST_CKPT_EN
         base = m_ckpt;
`else
         base = '0;
`endif
      end
      e_valid = pv && !fl;
      if (pv && !fl) begin
         e_idx  = model_idx(p, m_ghr);
         e_tag  = model_tag(p, m_ghr);
         m_ckpt = m_ghr;
      end
      m_ghr = bv ? {base[62:0], bt} : base;
      @(posedge clk);
      #1;
      pc_valid = 0; br_valid = 0; flush = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pc_valid = 0; br_valid = 0; br_taken = 0; flush = 0; pc = '0;
      m_ghr = '0; m_ckpt = '0; e_valid = 0; e_idx = '0; e_tag = '0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++;
      if ({hash_valid, hash_idx, hash_tag, ghr} !== '0)
         $display("FAIL reset_state: got valid=%0b idx=%h tag=%h ghr=%h, want all 0",
                  hash_valid, hash_idx, hash_tag, ghr);
      else pass_cnt++;
      cycle(1, 32'h0000_0404, 0, 0, 0);
      chk_cnt++;
      if (hash_valid !== 1'b1 || hash_idx !== 10'h101 || hash_tag !== 9'h101)
         $display("FAIL first_lookup: got valid=%0b idx=%h tag=%h, want 1/101/101",
                  hash_valid, hash_idx, hash_tag);
      else pass_cnt++;
      cycle(0, 32'hffff_ffff, 0, 0, 0);
      chk_cnt++;
      if (hash_valid !== 1'b0 || hash_idx !== 10'h101 || hash_tag !== 9'h101)
         $display("FAIL idle_hold: got valid=%0b idx=%h tag=%h, want 0/101/101",
                  hash_valid, hash_idx, hash_tag);
      else pass_cnt++;
   endtask

   task automatic test_single_update();
      do_reset();
      cycle(0, 0, 1, 1, 0);
      cycle(1, 0, 0, 0, 0);
      chk_cnt++;
      if (hash_idx !== 10'h001 || hash_tag !== 9'h003 || ghr !== 64'd1)
         $display("FAIL single_update: got idx=%h tag=%h ghr=%h, want 001/003/1",
                  hash_idx, hash_tag, ghr);
      else pass_cnt++;
   endtask

   task automatic test_random_history();
      do_reset();
      for (int n = 0; n < 200; n++) begin
         cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 0);
         chk_cnt++;
         if (ghr !== m_ghr || hash_valid !== e_valid ||
             (e_valid && (hash_idx !== e_idx || hash_tag !== e_tag)))
            $display("FAIL random_hist[%0d]: got ghr=%h v=%0b idx=%h tag=%h, want ghr=%h v=%0b idx=%h tag=%h",
                     n, ghr, hash_valid, hash_idx, hash_tag, m_ghr, e_valid, e_idx, e_tag);
         else pass_cnt++;
      end
      for (int n = 0; n < 33; n++) cycle(0, 0, 1, 1, 0);
      cycle(1, 0, 0, 0, 0);
      chk_cnt++;
      if (ghr[32] !== 1'b1 || ghr !== m_ghr || hash_idx !== e_idx || hash_tag !== e_tag)
         $display("FAIL taken33: got ghr=%h idx=%h tag=%h, want ghr=%h idx=%h tag=%h",
                  ghr, hash_idx, hash_tag, m_ghr, e_idx, e_tag);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      cycle(1, 0, 1, 1, 0);
      chk_cnt++;
      if (hash_idx !== 10'h000 || hash_tag !== 9'h000 || hash_valid !== 1'b1)
         $display("FAIL same_cycle_pre: got idx=%h tag=%h v=%0b, want 000/000/1",
                  hash_idx, hash_tag, hash_valid);
      else pass_cnt++;
      cycle(1, 0, 0, 0, 0);
      chk_cnt++;
      if (hash_idx !== 10'h001)
         $display("FAIL same_cycle_post: got idx=%h, want 001", hash_idx);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      do_reset();
      cycle(1, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 1, 1, 0);
      cycle(1, 0, 1, 0, 1);
      chk_cnt++;
      if (ghr !== 64'd0 || hash_valid !== 1'b0)
         $display("FAIL flush_repair: got ghr=%h v=%0b, want 0/0", ghr, hash_valid);
      else pass_cnt++;
      cycle(1, 0, 0, 0, 0);
      chk_cnt++;
      if (hash_idx !== 10'h000 || hash_tag !== 9'h000)
         $display("FAIL flush_folds: got idx=%h tag=%h, want 000/000", hash_idx, hash_tag);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int n = 0; n < 150; n++) begin
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 7) == 0);
         chk_cnt++;
         if (ghr !== m_ghr || hash_valid !== e_valid ||
             (e_valid && (hash_idx !== e_idx || hash_tag !== e_tag)))
            $display("FAIL b2b_flush[%0d]: got ghr=%h v=%0b idx=%h tag=%h, want ghr=%h v=%0b idx=%h tag=%h",
                     n, ghr, hash_valid, hash_idx, hash_tag, m_ghr, e_valid, e_idx, e_tag);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (5) cycle(0, 0, 1, 1, 0);
      cycle(1, 32'h0012_3404, 0, 0, 0);
      chk_cnt++;
      if (hash_valid !== 1'b1 || ghr !== 64'h1f)
         $display("FAIL pre_reset: got v=%0b ghr=%h, want 1/1f", hash_valid, ghr);
      else pass_cnt++;
      pc_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_cnt++;
      if ({hash_valid, hash_idx, hash_tag, ghr} !== '0)
         $display("FAIL async_reset: got v=%0b idx=%h tag=%h ghr=%h, want all 0",
                  hash_valid, hash_idx, hash_tag, ghr);
      else pass_cnt++;
      br_valid = 1'b1; br_taken = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if ({hash_valid, hash_idx, hash_tag, ghr} !== '0)
         $display("FAIL reset_hold: got v=%0b idx=%h tag=%h ghr=%h, want all 0",
                  hash_valid, hash_idx, hash_tag, ghr);
      else pass_cnt++;
      pc_valid = 0; br_valid = 0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_update();
      test_random_history();
      test_same_cycle();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
